// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: sector tags and angle offsets used by the
// input-side reduction and the output-side quadrant restore.
package cordic_pkg;

  typedef enum logic [1:0] {
    SEC_S1 = 2'b00,
    SEC_S4 = 2'b01,
    SEC_S2 = 2'b10,
    SEC_S3 = 2'b11
  } sector_e;

  localparam int ANGLE_P90_C  = 90;
  localparam int ANGLE_N90_C  = -90;
  localparam int ANGLE_P180_C = 180;

endpackage

// File: rtl/interface_output_if.sv
// Core-to-output and output-to-downstream handshake bundle.
// master = core/downstream environment, slave = interface_output.
interface interface_output_if #(
  parameter int W  = 16,
  parameter int SW = 2
);
  logic [W-1:0]  x_out;
  logic [W-1:0]  y_out;
  logic [W-1:0]  degree_out;
  logic [SW-1:0] sector_out;
  logic          arctan_en_out;
  logic          valid_out;
  logic          ready_out;

  logic [W-1:0]  cos_interface;
  logic [W-1:0]  sin_interface;
  logic [W-1:0]  degree_out_interface;
  logic          arctan_en_out_interface;
  logic          valid_out_interface;
  logic          ready_in_interface;

  modport master (
    output x_out, y_out, degree_out, sector_out, arctan_en_out, valid_out,
    output ready_in_interface,
    input  ready_out,
    input  cos_interface, sin_interface, degree_out_interface,
    input  arctan_en_out_interface, valid_out_interface
  );

  modport slave (
    input  x_out, y_out, degree_out, sector_out, arctan_en_out, valid_out,
    input  ready_in_interface,
    output ready_out,
    output cos_interface, sin_interface, degree_out_interface,
    output arctan_en_out_interface, valid_out_interface
  );
endinterface

// File: rtl/interface_output_skid.sv
// One-entry skid register for interface_output; used only when
// INTERFACE_OUTPUT_SKID_EN is defined.
module interface_output_skid #(
  parameter int DW = 49
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          unload_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic [DW-1:0] data_o
);
  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
endmodule

// File: rtl/interface_output.sv
// CORDIC output stage: quadrant restore into a one-cycle output register.
// Define INTERFACE_OUTPUT_SKID_EN to add a skid entry and a registered ready_out.
module interface_output
  import cordic_pkg::*;
#(
  parameter int UNSIGNED_OUTPUT_WIDTH = 16,
  parameter int SECTOR_FLAG_WIDTH     = 2,
  parameter logic [SECTOR_FLAG_WIDTH-1:0] S1 = SECTOR_FLAG_WIDTH'(SEC_S1),
  parameter logic [SECTOR_FLAG_WIDTH-1:0] S2 = SECTOR_FLAG_WIDTH'(SEC_S2),
  parameter logic [SECTOR_FLAG_WIDTH-1:0] S3 = SECTOR_FLAG_WIDTH'(SEC_S3),
  parameter logic [SECTOR_FLAG_WIDTH-1:0] S4 = SECTOR_FLAG_WIDTH'(SEC_S4),
  parameter int ANGLE_P90  = ANGLE_P90_C,
  parameter int ANGLE_N90  = ANGLE_N90_C,
  parameter int ANGLE_P180 = ANGLE_P180_C
) (
  input  logic             clk,
  input  logic             rst,
  interface_output_if.slave bus
);
  localparam int W  = UNSIGNED_OUTPUT_WIDTH;
  localparam int SW = SECTOR_FLAG_WIDTH;

  typedef struct packed {
    logic [W-1:0] cos_v;
    logic [W-1:0] sin_v;
    logic [W-1:0] deg_v;
    logic         atan_v;
  } out_t;

  // Negating the most negative code would wrap back to itself; clamp instead.
  function automatic logic [W-1:0] sat_neg(input logic [W-1:0] v);
    logic [W-1:0] most_neg;
    most_neg = {1'b1, {(W-1){1'b0}}};
    if (v == most_neg) return ~most_neg;
    return -v;
  endfunction

  function automatic out_t restore(input logic [W-1:0]  x,
                                   input logic [W-1:0]  y,
                                   input logic [W-1:0]  d,
                                   input logic [SW-1:0] sec,
                                   input logic          atan);
    out_t         r;
    logic [W-1:0] off;
    r.cos_v  = x;
    r.sin_v  = y;
    r.atan_v = atan;
    off      = '0;
    if (sec == S2) begin
      off = W'(ANGLE_P90);
      if (!atan) begin
        r.cos_v = sat_neg(y);
        r.sin_v = x;
      end
    end else if (sec == S3) begin
      off = W'(-ANGLE_P180);
      if (!atan) begin
        r.cos_v = sat_neg(x);
        r.sin_v = sat_neg(y);
      end
    end else if (sec == S4) begin
      off = W'(ANGLE_N90);
      if (!atan) begin
        r.cos_v = y;
        r.sin_v = sat_neg(x);
      end
    end
    r.deg_v = d + off;
    return r;
  endfunction

  out_t restored, out_q, out_d;
  logic valid_q, valid_d;
  logic ready_int, accept;

  assign restored = restore(bus.x_out, bus.y_out, bus.degree_out,
                            bus.sector_out, bus.arctan_en_out);
  assign accept   = bus.valid_out & ready_int;

`ifdef INTERFACE_OUTPUT_SKID_EN
  logic skid_full, skid_load, skid_unload, space;
  logic [$bits(out_t)-1:0] skid_data;

  interface_output_skid #(.DW($bits(out_t))) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (restored),
    .full_o   (skid_full),
    .data_o   (skid_data)
  );

  assign ready_int = ~skid_full;
  assign space     = ~valid_q | bus.ready_in_interface;

  always_comb begin
    out_d       = out_q;
    valid_d     = valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (skid_full) begin
      if (space) begin
        out_d       = skid_data;
        valid_d     = 1'b1;
        skid_unload = 1'b1;
      end
    end else if (accept) begin
      if (space) begin
        out_d   = restored;
        valid_d = 1'b1;
      end else begin
        skid_load = 1'b1;
      end
    end else if (bus.ready_in_interface) begin
      valid_d = 1'b0;
    end
  end
`else
  assign ready_int = ~valid_q | bus.ready_in_interface;

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (accept) begin
      out_d   = restored;
      valid_d = 1'b1;
    end else if (bus.ready_in_interface) begin
      valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  // Gating with rst holds ready_out low for the whole reset window.
  assign bus.ready_out               = rst & ready_int;
  assign bus.cos_interface           = out_q.cos_v;
  assign bus.sin_interface           = out_q.sin_v;
  assign bus.degree_out_interface    = out_q.deg_v;
  assign bus.arctan_en_out_interface = out_q.atan_v;
  assign bus.valid_out_interface     = valid_q;
endmodule

// File: tb/tb_interface_output.sv
// Directed self-checking bench for interface_output: restore vectors,
// backpressure streaming, back-to-back throughput and mid-transfer reset.
module tb_interface_output;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] S1 = 2'b00, S2 = 2'b10, S3 = 2'b11, S4 = 2'b01;

  interface_output_if #(.W(16), .SW(2)) bus ();

  interface_output #(
    .UNSIGNED_OUTPUT_WIDTH(16),
    .SECTOR_FLAG_WIDTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic a,
                       input logic [15:0] x, input logic [15:0] y, input logic [15:0] d);
    bus.valid_out     = v;
    bus.sector_out    = s;
    bus.arctan_en_out = a;
    bus.x_out         = x;
    bus.y_out         = y;
    bus.degree_out    = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] c, input logic [15:0] s,
                         input logic [15:0] d, input logic a);
    chk({tag, "_valid"}, 16'(bus.valid_out_interface), 16'd1);
    chk({tag, "_cos"}, bus.cos_interface, c);
    chk({tag, "_sin"}, bus.sin_interface, s);
    chk({tag, "_deg"}, bus.degree_out_interface, d);
    chk({tag, "_atan"}, 16'(bus.arctan_en_out_interface), 16'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, stall_n;
    logic acc, drn, hold;
    logic [15:0] held_cos;

    drive(1'b0, S1, 1'b0, 16'h0, 16'h0, 16'h0);
    bus.ready_in_interface = 1'b1;
    #2;
    chk("rst_valid", 16'(bus.valid_out_interface), 16'd0);
    chk("rst_ready", 16'(bus.ready_out), 16'd0);
    chk("rst_cos", bus.cos_interface, 16'h0);
    chk("rst_deg", bus.degree_out_interface, 16'h0);
    tick;
    rst = 1'b1;
    #1;
    chk("ready_after_rst", 16'(bus.ready_out), 16'd1);

    drive(1'b1, S2, 1'b0, 16'h00DD, 16'h0080, 16'd30);
    tick;
    chk_out("rot_s2", 16'hFF80, 16'h00DD, 16'h0078, 1'b0);
    drive(1'b1, S3, 1'b0, 16'h8000, 16'h0100, 16'd45);
    tick;
    chk_out("rot_s3_sat", 16'h7FFF, 16'hFF00, 16'hFF79, 1'b0);
    drive(1'b1, S4, 1'b1, 16'h1234, 16'h0567, 16'd60);
    tick;
    chk_out("atan_s4", 16'h1234, 16'h0567, 16'hFFE2, 1'b1);
    drive(1'b1, S4, 1'b0, 16'h0300, 16'h0050, 16'd80);
    tick;
    chk_out("rot_s4", 16'h0050, 16'hFD00, 16'hFFF6, 1'b0);
    drive(1'b1, S1, 1'b0, 16'h0100, 16'h0200, 16'd10);
    tick;
    chk_out("rot_s1", 16'h0100, 16'h0200, 16'h000A, 1'b0);
    drive(1'b1, S2, 1'b1, 16'h0AAA, 16'h0BBB, 16'd10);
    tick;
    chk_out("atan_s2", 16'h0AAA, 16'h0BBB, 16'h0064, 1'b1);
    drive(1'b0, S1, 1'b0, 16'h0, 16'h0, 16'h0);
    tick;
    chk("idle_valid", 16'(bus.valid_out_interface), 16'd0);

    // Eight samples with a five-cycle downstream stall.
    sent = 0;
    got = 0;
    stall_n = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      bus.ready_in_interface = !(cyc >= 3 && cyc <= 7);
      if (sent < 8)
        drive(1'b1, S1, 1'b0, 16'(16'h0010 + sent), 16'(16'h0020 + sent), 16'(sent));
      else
        drive(1'b0, S1, 1'b0, 16'h0, 16'h0, 16'h0);
      #1;
      acc  = bus.valid_out && bus.ready_out;
      drn  = bus.valid_out_interface && bus.ready_in_interface;
      hold = bus.valid_out_interface && !bus.ready_in_interface;
      held_cos = bus.cos_interface;
      if (drn) begin
        chk("stream_cos", bus.cos_interface, 16'(16'h0010 + got));
        chk("stream_deg", bus.degree_out_interface, 16'(got));
      end
      if (hold) begin
`ifdef INTERFACE_OUTPUT_SKID_EN
        chk("stall_ready", 16'(bus.ready_out), 16'(stall_n == 0));
`else
        chk("stall_ready", 16'(bus.ready_out), 16'd0);
`endif
        stall_n++;
      end
      tick;
      if (hold) begin
        chk("stall_hold_valid", 16'(bus.valid_out_interface), 16'd1);
        chk("stall_hold_cos", bus.cos_interface, held_cos);
      end
      if (acc) sent++;
      if (drn) got++;
    end
    chk("stream_count", 16'(got), 16'd8);
    chk("stall_cycles", 16'(stall_n), 16'd5);

    // Sixteen back-to-back samples at full rate.
    bus.ready_in_interface = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, S2, 1'b0, 16'(16'h0100 + i), 16'(16'h0040 + i), 16'(i));
      #1;
      chk("b2b_ready", 16'(bus.ready_out), 16'd1);
      tick;
      chk_out("b2b", 16'(16'h0000 - (16'h0040 + i)), 16'(16'h0100 + i), 16'(i + 90), 1'b0);
    end
    drive(1'b0, S1, 1'b0, 16'h0, 16'h0, 16'h0);
    tick;
    chk("b2b_drain", 16'(bus.valid_out_interface), 16'd0);

    // Reset while a sample is held.
    drive(1'b1, S1, 1'b0, 16'h0777, 16'h0888, 16'd5);
    tick;
    bus.ready_in_interface = 1'b0;
    drive(1'b0, S1, 1'b0, 16'h0, 16'h0, 16'h0);
    tick;
    chk_out("pre_rst_hold", 16'h0777, 16'h0888, 16'h0005, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 16'(bus.valid_out_interface), 16'd0);
    chk("midrst_cos", bus.cos_interface, 16'h0);
    chk("midrst_sin", bus.sin_interface, 16'h0);
    chk("midrst_deg", bus.degree_out_interface, 16'h0);
    chk("midrst_ready", 16'(bus.ready_out), 16'd0);
    tick;
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 16'(bus.ready_out), 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_no_stale", 16'(bus.valid_out_interface), 16'd0);
    end
    bus.ready_in_interface = 1'b1;
    drive(1'b1, S3, 1'b0, 16'h0010, 16'h0020, 16'd0);
    tick;
    chk_out("post_rst_new", 16'hFFF0, 16'hFFE0, 16'hFF4C, 1'b0);
    drive(1'b0, S1, 1'b0, 16'h0, 16'h0, 16'h0);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
